// File: rtl/mesh_router_xy.sv
// 5-port XY mesh router: input FIFOs, per-output round-robin arbiters, 1-entry output registers.
// Optional NOC_STATS_EN adds stat_fwd, one saturating forward counter per output port.
module mesh_router_xy #(
  parameter int FLIT_W     = 34,
  parameter int MESH_X     = 2,
  parameter int MESH_Y     = 2,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*FLIT_W-1:0] in_flit,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_ready,
  output logic [5*FLIT_W-1:0] out_flit,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_ready,
  output logic                route_err
`ifdef NOC_STATS_EN
  ,
  output logic [5*16-1:0]     stat_fwd
`endif
);

  localparam int XW = ($clog2(MESH_X) > 1) ? $clog2(MESH_X) : 1;
  localparam int YW = ($clog2(MESH_Y) > 1) ? $clog2(MESH_Y) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    P_L = 3'd0,
    P_N = 3'd1,
    P_S = 3'd2,
    P_E = 3'd3,
    P_W = 3'd4
  } port_e;

  logic [FLIT_W-1:0] mem_q  [5][FIFO_DEPTH];
  logic [PW-1:0]     wptr_q [5];
  logic [PW-1:0]     rptr_q [5];
  logic [CW-1:0]     cnt_q  [5];
  logic [2:0]        ptr_q  [5];
  logic [FLIT_W-1:0] out_flit_q [5];
  logic [4:0]        out_valid_q;
  logic              err_q;

  logic [FLIT_W-1:0] head [5];
  logic [XW-1:0]     dx   [5];
  logic [YW-1:0]     dy   [5];
  port_e             route [5];
  logic [4:0]        hv, oor, push, pop;
  logic [4:0]        gnt_valid;
  logic [2:0]        gnt_idx [5];
  logic [3:0]        sum;
  logic [2:0]        cand;

  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      head[i]     = mem_q[i][rptr_q[i]];
      dx[i]       = head[i][FLIT_W-1 -: XW];
      dy[i]       = head[i][FLIT_W-1-XW -: YW];
      hv[i]       = (cnt_q[i] != '0);
      in_ready[i] = rst && (cnt_q[i] != CW'(FIFO_DEPTH));
      push[i]     = in_valid[i] && in_ready[i];
      oor[i]      = (int'(dx[i]) >= MESH_X) || (int'(dy[i]) >= MESH_Y);
      if (oor[i])                    route[i] = P_L;
      else if (int'(dx[i]) > X_ID)   route[i] = P_E;
      else if (int'(dx[i]) < X_ID)   route[i] = P_W;
      else if (int'(dy[i]) > Y_ID)   route[i] = P_S;
      else if (int'(dy[i]) < Y_ID)   route[i] = P_N;
      else                           route[i] = P_L;
    end
  end

  // Each head routes to exactly one output, so an input never wins two outputs at once.
  always_comb begin
    gnt_valid = '0;
    pop       = '0;
    sum       = '0;
    cand      = '0;
    for (int unsigned o = 0; o < 5; o++) begin
      gnt_idx[o] = '0;
      if (!out_valid_q[o] || out_ready[o]) begin
        for (int unsigned k = 1; k <= 5; k++) begin
          sum  = {1'b0, ptr_q[o]} + 4'(k);
          cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
          if (!gnt_valid[o] && hv[cand] && (route[cand] == port_e'(o))) begin
            gnt_valid[o] = 1'b1;
            gnt_idx[o]   = cand;
          end
        end
      end
      if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 5; i++) begin
        wptr_q[i]     <= '0;
        rptr_q[i]     <= '0;
        cnt_q[i]      <= '0;
        ptr_q[i]      <= 3'd4;
        out_flit_q[i] <= '0;
      end
      out_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (push[i]) begin
          mem_q[i][wptr_q[i]] <= in_flit[i*FLIT_W +: FLIT_W];
          wptr_q[i]           <= wptr_q[i] + PW'(1);
        end
        if (pop[i]) rptr_q[i] <= rptr_q[i] + PW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      for (int unsigned o = 0; o < 5; o++) begin
        if (gnt_valid[o]) begin
          out_flit_q[o]  <= head[gnt_idx[o]];
          out_valid_q[o] <= 1'b1;
          ptr_q[o]       <= gnt_idx[o];
        end else if (out_ready[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
      err_q <= gnt_valid[0] && oor[gnt_idx[0]];
    end
  end

  always_comb begin
    out_flit = '0;
    for (int unsigned o = 0; o < 5; o++) out_flit[o*FLIT_W +: FLIT_W] = out_flit_q[o];
  end

  assign out_valid = out_valid_q;
  assign route_err = err_q;

`ifdef NOC_STATS_EN
  logic [4:0][15:0] stat_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      for (int unsigned o = 0; o < 5; o++) begin
        if (out_valid_q[o] && out_ready[o] && (stat_q[o] != 16'hFFFF))
          stat_q[o] <= stat_q[o] + 16'd1;
      end
    end
  end

  assign stat_fwd = stat_q;
`endif

endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed bench for mesh_router_xy on a 3x3 mesh, router at (1,1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mesh_router_xy;
  localparam int FW = 34;

  logic            clk = 1'b0;
  logic            rst;
  logic [5*FW-1:0] in_flit;
  logic [4:0]      in_valid;
  logic [4:0]      in_ready;
  logic [5*FW-1:0] out_flit;
  logic [4:0]      out_valid;
  logic [4:0]      out_ready;
  logic            route_err;
`ifdef NOC_STATS_EN
  logic [5*16-1:0] stat_fwd;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  mesh_router_xy #(
    .FLIT_W(FW), .MESH_X(3), .MESH_Y(3), .X_ID(1), .Y_ID(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .route_err(route_err)
`ifdef NOC_STATS_EN
    , .stat_fwd(stat_fwd)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] x, input logic [1:0] y,
                                       input logic [29:0] pl);
    return {x, y, pl};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = '0; in_flit = '0; out_ready = '1;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (in_ready !== 5'b00000) $display("FAIL reset_in_ready: got %b required 00000", in_ready);
    else n_pass++;
    n_total++;
    if (out_valid !== 5'b00000) $display("FAIL reset_out_valid: got %b required 00000", out_valid);
    else n_pass++;
    n_total++;
    if (out_flit !== '0) $display("FAIL reset_out_flit: got %h required 0", out_flit);
    else n_pass++;
    n_total++;
    if (route_err !== 1'b0) $display("FAIL reset_route_err: got %b required 0", route_err);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 5'b11111) $display("FAIL release_in_ready: got %b required 11111", in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_routing();
    logic [FW-1:0] f;
    f = mk(2'd2, 2'd1, 30'h0ABC);
    out_ready = '1;
    in_flit[0*FW +: FW] = f;
    in_valid = 5'b00001;
    @(negedge clk);
    in_valid = '0;
    n_total++;
    if (out_valid !== 5'b00000) $display("FAIL route_early: got %b required 00000", out_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 5'b01000) $display("FAIL route_valid: got %b required 01000", out_valid);
    else n_pass++;
    n_total++;
    if (out_flit[3*FW +: FW] !== f)
      $display("FAIL route_flit: got %h required %h", out_flit[3*FW +: FW], f);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 5'b00000) $display("FAIL route_drain: got %b required 00000", out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int unsigned accepted;
    logic [FW-1:0] exp_f;
    accepted = 0;
    out_ready = 5'b10111;
    for (int unsigned c = 0; c < 8; c++) begin
      in_flit[0*FW +: FW] = mk(2'd2, 2'd1, 30'(100 + accepted));
      in_valid = 5'b00001;
      #1;
      if (in_ready[0]) accepted++;
      @(negedge clk);
    end
    n_total++;
    if (accepted !== 5) $display("FAIL bp_accepted: got %0d required 5", accepted);
    else n_pass++;
    n_total++;
    if (in_ready[0] !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", in_ready[0]);
    else n_pass++;
    in_valid = '0;
    out_ready = '1;
    for (int unsigned k = 0; k < 5; k++) begin
      exp_f = mk(2'd2, 2'd1, 30'(100 + k));
      n_total++;
      if (!out_valid[3] || out_flit[3*FW +: FW] !== exp_f)
        $display("FAIL bp_drain_%0d: got valid=%b flit=%h required valid=1 flit=%h",
                 k, out_valid[3], out_flit[3*FW +: FW], exp_f);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (out_valid !== 5'b00000) $display("FAIL bp_empty: got %b required 00000", out_valid);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    logic [FW-1:0] fn, fw, exp_f;
    fn = mk(2'd1, 2'd1, 30'h111);
    fw = mk(2'd1, 2'd1, 30'h444);
    do_reset();
    out_ready = '1;
    in_flit[1*FW +: FW] = fn;
    in_flit[4*FW +: FW] = fw;
    in_valid = 5'b10010;
    @(negedge clk);
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_f = (k % 2 == 0) ? fn : fw;
      n_total++;
      if (out_valid !== 5'b00001 || out_flit[0*FW +: FW] !== exp_f)
        $display("FAIL arb_%0d: got valid=%b flit=%h required valid=00001 flit=%h",
                 k, out_valid, out_flit[0*FW +: FW], exp_f);
      else n_pass++;
    end
    in_valid = '0;
  endtask

  task automatic test_error();
    logic [FW-1:0] f;
    f = mk(2'd3, 2'd1, 30'h0E0);
    do_reset();
    out_ready = '1;
    in_flit[0*FW +: FW] = f;
    in_valid = 5'b00001;
    @(negedge clk);
    in_valid = '0;
    n_total++;
    if (route_err !== 1'b0) $display("FAIL err_early: got %b required 0", route_err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 5'b00001 || out_flit[0*FW +: FW] !== f || route_err !== 1'b1)
      $display("FAIL err_deliver: got valid=%b flit=%h err=%b required valid=00001 flit=%h err=1",
               out_valid, out_flit[0*FW +: FW], route_err, f);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (route_err !== 1'b0) $display("FAIL err_pulse: got %b required 0", route_err);
    else n_pass++;
  endtask

  task automatic test_midreset();
    int unsigned stale;
    stale = 0;
    out_ready = 5'b10111;
    for (int unsigned c = 0; c < 4; c++) begin
      in_flit[0*FW +: FW] = mk(2'd2, 2'd1, 30'(200 + c));
      in_valid = 5'b00001;
      @(negedge clk);
    end
    in_valid = '0;
    n_total++;
    if (out_valid !== 5'b01000) $display("FAIL mr_loaded: got %b required 01000", out_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 5'b00000) $display("FAIL mr_in_ready_low: got %b required 00000", in_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 5'b00000) $display("FAIL mr_out_valid: got %b required 00000", out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 5'b11111) $display("FAIL mr_in_ready: got %b required 11111", in_ready);
    else n_pass++;
    out_ready = '1;
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid !== 5'b00000) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL mr_stale: got %0d stale cycles required 0", stale);
    else n_pass++;
  endtask

`ifdef NOC_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = '1;
    for (int unsigned c = 0; c < 3; c++) begin
      in_flit[0*FW +: FW] = mk(2'd2, 2'd1, 30'(300 + c));
      in_valid = 5'b00001;
      @(negedge clk);
    end
    in_valid = '0;
    repeat (4) @(negedge clk);
    n_total++;
    if (stat_fwd[3*16 +: 16] !== 16'd3)
      $display("FAIL stats_count: got %0d required 3", stat_fwd[3*16 +: 16]);
    else n_pass++;
    force dut.stat_q = {16'h0000, 16'hFFFF, 48'h0};
    @(negedge clk);
    release dut.stat_q;
    in_flit[0*FW +: FW] = mk(2'd2, 2'd1, 30'h3FF);
    in_valid = 5'b00001;
    @(negedge clk);
    in_valid = '0;
    repeat (4) @(negedge clk);
    n_total++;
    if (stat_fwd[3*16 +: 16] !== 16'hFFFF)
      $display("FAIL stats_sat: got %h required ffff", stat_fwd[3*16 +: 16]);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_arbitration();
    test_error();
    test_midreset();
`ifdef NOC_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
